// File: rtl/gcd_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : gcd_arbiter_if
//  Description : Bus between the GCD arbiter and the single GCD slave.
//                The slave accepts a one-cycle request only while busy is low
//                and later strobes its result with valid.
//  Ports       : slv_req    - one-cycle request to the slave (arbiter drives)
//                slv_a/b    - operands, registered copies (arbiter drives)
//                slv_busy   - slave cannot accept a request (slave drives)
//                slv_valid  - result strobe (slave drives)
//                slv_result - result, qualified by slv_valid (slave drives)
//  Revision    : 1.0 - initial release
// ============================================================================
interface gcd_arbiter_if #(
  parameter int W = 4
);
  logic         slv_req;
  logic [W-1:0] slv_a;
  logic [W-1:0] slv_b;
  logic         slv_busy;
  logic         slv_valid;
  logic [W-1:0] slv_result;

  // Arbiter side
  modport master (
    output slv_req, slv_a, slv_b,
    input  slv_busy, slv_valid, slv_result
  );

  // GCD slave side
  modport slave (
    input  slv_req, slv_a, slv_b,
    output slv_busy, slv_valid, slv_result
  );
endinterface
`default_nettype wire

// File: rtl/gcd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : gcd_arbiter
//  Description : Shares one GCD slave between N_REQ requesters. Round-robin
//                grant, captures the winner's operands, issues one slave
//                request, waits (bounded by TIMEOUT) for the result and
//                returns it tagged with the requester id.
//  Ports       : clk_i        - clock, rising edge
//                rst_ni       - asynchronous reset, active low
//                req_i        - per-requester level request, held until ack_o
//                a_i / b_i    - packed operands, slice i = x[i*W +: W]
//                ack_o        - one-cycle pulse to the served requester
//                rsp_valid_o  - one-cycle response strobe (with ack_o)
//                rsp_id_o     - served requester id
//                rsp_data_o   - GCD result (0 on timeout)
//                rsp_err_o    - timeout flag
//                slv          - master side of the slave bus
//  Revision    : 1.0 - initial release
// ============================================================================
module gcd_arbiter #(
  parameter  int N_REQ   = 4,
  parameter  int W       = 4,
  parameter  int TIMEOUT = 64,
  localparam int IDW     = $clog2(N_REQ),
  localparam int TW      = $clog2(TIMEOUT + 1)
) (
  input  wire logic                 clk_i,
  input  wire logic                 rst_ni,
  input  wire logic [N_REQ-1:0]     req_i,
  input  wire logic [N_REQ*W-1:0]   a_i,
  input  wire logic [N_REQ*W-1:0]   b_i,
  output logic      [N_REQ-1:0]     ack_o,
  output logic                      rsp_valid_o,
  output logic      [IDW-1:0]       rsp_id_o,
  output logic      [W-1:0]         rsp_data_o,
  output logic                      rsp_err_o,
  gcd_arbiter_if.master             slv
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q,   ptr_d;
  logic [IDW-1:0] id_q,    id_d;
  logic [W-1:0]   a_q,     a_d;
  logic [W-1:0]   b_q,     b_d;
  logic [W-1:0]   data_q,  data_d;
  logic           err_q,   err_d;
  logic [TW-1:0]  timer_q, timer_d;

  // --------------------------------------------------------------------------
  // Round-robin pick: first requester at or after ptr_q, wrapping mod N_REQ.
  // The sum is one bit wider than an id so the wrap works for any N_REQ.
  // --------------------------------------------------------------------------
  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [IDW:0]   cand;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(N_REQ)) begin
        cand = cand - (IDW+1)'(N_REQ);
      end
      if (!win_found && req_i[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[IDW-1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // State register and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    data_d      = data_q;
    err_d       = err_q;
    timer_d     = timer_q;
    slv.slv_req = 1'b0;
    ack_o       = '0;
    rsp_valid_o = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Operands are captured here; later a_i/b_i/req_i changes are ignored.
        if (win_found) begin
          id_d    = win_id;
          a_d     = a_i[win_id*W +: W];
          b_d     = b_i[win_id*W +: W];
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // Waiting on a busy slave is unbounded; the timer only runs in WAIT.
        if (!slv.slv_busy) begin
          slv.slv_req = 1'b1;
          timer_d     = '0;
          state_d     = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // A result arriving on the last allowed cycle still beats the timeout.
        if (slv.slv_valid) begin
          data_d  = slv.slv_result;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      ST_RESP: begin
        rsp_valid_o = 1'b1;
        ack_o[id_q] = 1'b1;
        ptr_d       = (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + IDW'(1);
        state_d     = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign slv.slv_a  = a_q;
  assign slv.slv_b  = b_q;
  assign rsp_id_o   = id_q;
  assign rsp_data_o = data_q;
  assign rsp_err_o  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_gcd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gcd_arbiter
//  Description : Self-checking bench for gcd_arbiter. Acts as requesters and
//                as a stub GCD slave; expected grants, operands, results and
//                latencies come from a round-robin / Euclid reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gcd_arbiter;

  localparam int N_REQ   = 4;
  localparam int W       = 4;
  localparam int TIMEOUT = 64;
  localparam int IDW     = $clog2(N_REQ);

  logic                 clk_i  = 1'b0;
  logic                 rst_ni = 1'b0;
  logic [N_REQ-1:0]     req_i  = '0;
  logic [N_REQ*W-1:0]   a_i    = '0;
  logic [N_REQ*W-1:0]   b_i    = '0;
  logic [N_REQ-1:0]     ack_o;
  logic                 rsp_valid_o;
  logic [IDW-1:0]       rsp_id_o;
  logic [W-1:0]         rsp_data_o;
  logic                 rsp_err_o;

  gcd_arbiter_if #(.W(W)) slv_if ();

  gcd_arbiter #(
    .N_REQ   (N_REQ),
    .W       (W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .ack_o       (ack_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_id_o    (rsp_id_o),
    .rsp_data_o  (rsp_data_o),
    .rsp_err_o   (rsp_err_o),
    .slv         (slv_if)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;
  int ptr_m = 0;
  int op_a [N_REQ];
  int op_b [N_REQ];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: grant is the first requesting index at or after the pointer.
  function automatic int rr_pick(input logic [N_REQ-1:0] req, input int ptr);
    for (int k = 0; k < N_REQ; k++) begin
      if (req[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
    end
    return -1;
  endfunction

  function automatic int gcd_ref(input int a, input int b);
    int x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int id, input int a, input int b);
    op_a[id]          = a;
    op_b[id]          = b;
    a_i[id*W +: W]    = W'(a);
    b_i[id*W +: W]    = W'(b);
    req_i[id]         = 1'b1;
  endtask

  // One full transaction starting from IDLE with at least one request up.
  // busy_cyc: slave busy cycles in ISSUE (stale valid is driven meanwhile).
  // delay   : WAIT cycles before valid; negative means the slave never answers.
  // perturb : change the winner's operand and drop its request after grant.
  task automatic run_txn(input int busy_cyc, input int delay, input bit perturb);
    int w, ea, eb, ed, ee;
    w = rr_pick(req_i, ptr_m);
    if (w < 0) begin
      n_err++;
      $display("FAIL txn_setup: observed no request, expected at least one");
      return;
    end
    ea = op_a[w];
    eb = op_b[w];
    tick();                                   // grant edge -> ISSUE
    if (perturb) begin
      a_i[w*W +: W] = ~W'(ea);
      b_i[w*W +: W] = ~W'(eb);
      req_i[w]      = 1'b0;
    end
    for (int i = 0; i < busy_cyc; i++) begin
      slv_if.slv_busy   = 1'b1;
      slv_if.slv_valid  = 1'b1;
      slv_if.slv_result = W'($urandom);
      @(negedge clk_i);
      check_val("slv_req_while_busy", slv_if.slv_req, 0);
      check_val("rsp_valid_in_issue", rsp_valid_o, 0);
      tick();
    end
    slv_if.slv_busy  = 1'b0;
    slv_if.slv_valid = 1'b0;
    @(negedge clk_i);
    check_val("slv_req_issue", slv_if.slv_req, 1);
    check_val("slv_a", slv_if.slv_a, ea);
    check_val("slv_b", slv_if.slv_b, eb);
    tick();                                   // WAIT, timer 0
    if (delay >= 0) begin
      for (int i = 0; i < delay; i++) begin
        @(negedge clk_i);
        check_val("slv_req_in_wait", slv_if.slv_req, 0);
        check_val("rsp_valid_in_wait", rsp_valid_o, 0);
        tick();
      end
      ed = gcd_ref(ea, eb);
      ee = 0;
      slv_if.slv_valid  = 1'b1;
      slv_if.slv_result = W'(ed);
      tick();
      slv_if.slv_valid  = 1'b0;
      slv_if.slv_result = W'($urandom);
    end else begin
      for (int i = 0; i < TIMEOUT; i++) begin
        @(negedge clk_i);
        check_val("rsp_valid_before_timeout", rsp_valid_o, 0);
        tick();
      end
      ed = 0;
      ee = 1;
    end
    @(negedge clk_i);                         // RESP cycle
    check_val("rsp_valid", rsp_valid_o, 1);
    check_val("ack", ack_o, 32'(1 << w));
    check_val("rsp_id", rsp_id_o, w);
    check_val("rsp_data", rsp_data_o, ed);
    check_val("rsp_err", rsp_err_o, ee);
    tick();
    req_i[w] = 1'b0;
    ptr_m    = (w + 1) % N_REQ;
    @(negedge clk_i);
    check_val("ack_one_cycle", ack_o, 0);
    check_val("rsp_valid_one_cycle", rsp_valid_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1);
  end

  initial begin
    int dly;
    slv_if.slv_busy   = 1'b0;
    slv_if.slv_valid  = 1'b0;
    slv_if.slv_result = '0;

    // Reset values
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_val("rst_ack", ack_o, 0);
    check_val("rst_rsp_valid", rsp_valid_o, 0);
    check_val("rst_rsp_id", rsp_id_o, 0);
    check_val("rst_rsp_data", rsp_data_o, 0);
    check_val("rst_rsp_err", rsp_err_o, 0);
    check_val("rst_slv_req", slv_if.slv_req, 0);
    check_val("rst_slv_a", slv_if.slv_a, 0);
    check_val("rst_slv_b", slv_if.slv_b, 0);
    tick();
    rst_ni = 1'b1;
    @(negedge clk_i);

    // T1: single requester, result five cycles after the slave request
    set_req(0, 12, 8);
    run_txn(0, 4, 1'b0);

    // T2: all four held; each served once in rotation, then wrap
    for (int r = 0; r < N_REQ; r++) set_req(r, $urandom_range(1, 15), $urandom_range(1, 15));
    for (int n = 0; n < N_REQ + 1; n++) begin
      run_txn(0, 1, 1'b0);
      for (int r = 0; r < N_REQ; r++)
        if (!req_i[r]) set_req(r, $urandom_range(1, 15), $urandom_range(1, 15));
    end
    req_i = '0;
    @(negedge clk_i);

    // T3: serve id1 (pointer -> 2), then 0011 must wrap to id0 first
    set_req(1, 9, 6);
    run_txn(0, 0, 1'b0);
    set_req(0, 10, 4);
    set_req(1, 15, 5);
    run_txn(0, 2, 1'b0);
    run_txn(0, 2, 1'b0);

    // T4: busy slave for 10 cycles
    set_req(2, 14, 7);
    run_txn(10, 3, 1'b0);

    // T5: timeout, then a normal transaction
    set_req(3, 6, 9);
    run_txn(0, -1, 1'b0);
    set_req(3, 8, 12);
    run_txn(0, 2, 1'b0);

    // Valid on the final allowed cycle beats the timeout
    set_req(1, 15, 10);
    run_txn(0, TIMEOUT - 1, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 30; t++) begin
      for (int r = 0; r < N_REQ; r++)
        if (!req_i[r] && $urandom_range(0, 1) == 1)
          set_req(r, $urandom_range(0, 15), $urandom_range(1, 15));
      if (req_i == '0) set_req($urandom_range(0, N_REQ - 1), $urandom_range(1, 15), $urandom_range(0, 15));
      dly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 12));
      run_txn($urandom_range(0, 3), dly, $urandom_range(0, 5) == 0);
    end
    req_i = '0;
    @(negedge clk_i);

    // T6: reset in the middle of WAIT, then a stale valid
    set_req(1, 4, 2);
    run_txn(0, 0, 1'b0);                      // pointer now 2
    set_req(2, 12, 3);
    tick();                                   // ISSUE
    tick();                                   // WAIT
    tick();
    tick();
    #2;
    rst_ni = 1'b0;
    req_i  = '0;
    @(negedge clk_i);
    check_val("t6_rst_ack", ack_o, 0);
    check_val("t6_rst_rsp_valid", rsp_valid_o, 0);
    check_val("t6_rst_slv_req", slv_if.slv_req, 0);
    check_val("t6_rst_slv_a", slv_if.slv_a, 0);
    check_val("t6_rst_rsp_id", rsp_id_o, 0);
    tick();
    rst_ni   = 1'b1;
    ptr_m    = 0;
    slv_if.slv_valid  = 1'b1;
    slv_if.slv_result = W'(5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check_val("t6_stale_rsp_valid", rsp_valid_o, 0);
      check_val("t6_stale_ack", ack_o, 0);
      tick();
    end
    slv_if.slv_valid = 1'b0;
    @(negedge clk_i);
    set_req(0, 9, 3);
    set_req(3, 10, 15);
    run_txn(0, 1, 1'b0);
    run_txn(0, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
